// File: rtl/pio_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : pio_input_conditioner
// Brief    : Synchronises and debounces pushbuttons and DIP switches, makes a
//            press pulse per button, and turns a long press into a warm-reset
//            request.
// Revision : 1.0 - initial release
// ============================================================================
module pio_input_conditioner #(
    parameter int N_BUTTON           = 2,
    parameter int N_DIPSW            = 4,
    parameter int DEBOUNCE_CYCLES    = 500000,
    parameter int LONG_PRESS_CYCLES  = 150000000,
    parameter int RESET_PULSE_CYCLES = 1024,
    parameter int LP_INDEX           = 0
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic [N_BUTTON-1:0] button_raw_n,
    input  logic [N_DIPSW-1:0]  dipsw_raw,
    input  logic                lp_enable,
    output logic [N_BUTTON-1:0] button_db_n,
    output logic [N_DIPSW-1:0]  dipsw_db,
    output logic [N_BUTTON-1:0] button_press_pulse,
    output logic                f2h_warm_reset_req_n
);

    localparam int c_N   = N_BUTTON + N_DIPSW;
    localparam int c_DBW = (DEBOUNCE_CYCLES > 1)    ? $clog2(DEBOUNCE_CYCLES)    : 1;
    localparam int c_HW  = (LONG_PRESS_CYCLES > 1)  ? $clog2(LONG_PRESS_CYCLES)  : 1;
    localparam int c_PW  = (RESET_PULSE_CYCLES > 1) ? $clog2(RESET_PULSE_CYCLES) : 1;

    localparam logic [c_DBW-1:0] c_DB_MAX    = c_DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_HW-1:0]  c_HOLD_MAX  = c_HW'(LONG_PRESS_CYCLES - 1);
    localparam logic [c_PW-1:0]  c_PULSE_MAX = c_PW'(RESET_PULSE_CYCLES - 1);

    // Buttons idle high (released), switches idle low.
    localparam logic [c_N-1:0] c_RST_VAL = {{N_DIPSW{1'b0}}, {N_BUTTON{1'b1}}};

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_HOLD     = 2'd1;
    localparam logic [1:0] c_ASSERT   = 2'd2;
    localparam logic [1:0] c_WAIT_REL = 2'd3;

    logic [c_N-1:0] w_raw;
    logic [c_N-1:0] w_db;

    assign w_raw = {dipsw_raw, button_raw_n};

    generate
        for (genvar i = 0; i < c_N; i++) begin : g_bit
            logic             r_s1;
            logic             r_s;
            logic             r_db;
            logic [c_DBW-1:0] r_cnt;

            always_ff @(posedge clk_clk) begin
                if (!reset_reset_n) begin
                    r_s1  <= c_RST_VAL[i];
                    r_s   <= c_RST_VAL[i];
                    r_db  <= c_RST_VAL[i];
                    r_cnt <= '0;
                end else begin
                    r_s1 <= w_raw[i];
                    r_s  <= r_s1;
                    if (r_s == r_db) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_DB_MAX) begin
                        r_db  <= r_s;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_DBW'(1);
                    end
                end
            end

            assign w_db[i] = r_db;
        end
    endgenerate

    assign button_db_n = w_db[N_BUTTON-1:0];
    assign dipsw_db    = w_db[c_N-1:N_BUTTON];

    logic [N_BUTTON-1:0] r_btn_prev;
    logic [N_BUTTON-1:0] r_press;

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_btn_prev <= '1;
            r_press    <= '0;
        end else begin
            r_btn_prev <= button_db_n;
            r_press    <= r_btn_prev & ~button_db_n;
        end
    end

    assign button_press_pulse = r_press;

    logic [1:0]      r_state;
    logic [c_HW-1:0] r_hold_cnt;
    logic [c_PW-1:0] r_pulse_cnt;
    logic            r_req_n;
    logic            w_lp_db;

    assign w_lp_db = button_db_n[LP_INDEX];

    // Disarming overrides every state, including a pulse already in flight.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n || !lp_enable) begin
            r_state     <= c_IDLE;
            r_hold_cnt  <= '0;
            r_pulse_cnt <= '0;
            r_req_n     <= 1'b1;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (!w_lp_db) begin
                        r_state    <= c_HOLD;
                        r_hold_cnt <= '0;
                    end
                end
                c_HOLD: begin
                    if (w_lp_db) begin
                        r_state <= c_IDLE;
                    end else if (r_hold_cnt == c_HOLD_MAX) begin
                        r_state     <= c_ASSERT;
                        r_pulse_cnt <= '0;
                        r_req_n     <= 1'b0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + c_HW'(1);
                    end
                end
                c_ASSERT: begin
                    if (r_pulse_cnt == c_PULSE_MAX) begin
                        r_state <= c_WAIT_REL;
                        r_req_n <= 1'b1;
                    end else begin
                        r_pulse_cnt <= r_pulse_cnt + c_PW'(1);
                    end
                end
                default: begin
                    r_req_n <= 1'b1;
                    if (w_lp_db) begin
                        r_state <= c_IDLE;
                    end
                end
            endcase
        end
    end

    assign f2h_warm_reset_req_n = r_req_n;

endmodule
`default_nettype wire

// File: tb/tb_pio_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_pio_input_conditioner
// Brief    : Scoreboard bench: a cycle model predicts every output per edge,
//            a monitor compares the DUT against the queued predictions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pio_input_conditioner;

    localparam int c_NB  = 2;
    localparam int c_ND  = 4;
    localparam int c_DB  = 4;
    localparam int c_LP  = 20;
    localparam int c_RP  = 5;
    localparam int c_LPI = 0;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [c_NB-1:0] btn_raw;
    logic [c_ND-1:0] dip_raw;
    logic            lp_en;
    logic [c_NB-1:0] btn_db;
    logic [c_ND-1:0] dip_db;
    logic [c_NB-1:0] press;
    logic            req_n;

    always #5 clk = ~clk;

    pio_input_conditioner #(
        .N_BUTTON(c_NB), .N_DIPSW(c_ND), .DEBOUNCE_CYCLES(c_DB),
        .LONG_PRESS_CYCLES(c_LP), .RESET_PULSE_CYCLES(c_RP), .LP_INDEX(c_LPI)
    ) u_dut (
        .clk_clk(clk), .reset_reset_n(rst_n), .button_raw_n(btn_raw),
        .dipsw_raw(dip_raw), .lp_enable(lp_en), .button_db_n(btn_db),
        .dipsw_db(dip_db), .button_press_pulse(press),
        .f2h_warm_reset_req_n(req_n)
    );

    typedef struct {
        logic [c_NB-1:0] bdb;
        logic [c_ND-1:0] ddb;
        logic [c_NB-1:0] pulse;
        logic            req;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Model state: a 2-deep sample history, a per-bit count of consecutive
    // disagreeing samples, and a long-press tracker built on edge counts.
    localparam int c_N = c_NB + c_ND;
    localparam logic [c_N-1:0] c_RST = {{c_ND{1'b0}}, {c_NB{1'b1}}};
    logic [c_N-1:0]  m_p1, m_p2, m_db;
    logic [c_NB-1:0] m_prev, m_pulse;
    int              m_mis[c_N];
    int              m_run, m_rem;
    bit              m_fired;
    logic            m_req;

    task automatic model_step();
        exp_t e;
        if (!rst_n) begin
            m_p1 = c_RST; m_p2 = c_RST; m_db = c_RST;
            m_prev = '1; m_pulse = '0;
            for (int i = 0; i < c_N; i++) m_mis[i] = 0;
            m_run = 0; m_rem = 0; m_fired = 0; m_req = 1'b1;
        end else begin
            m_pulse = m_prev & ~m_db[c_NB-1:0];
            m_prev  = m_db[c_NB-1:0];
            if (!lp_en) begin
                m_run = 0; m_rem = 0; m_fired = 0; m_req = 1'b1;
            end else if (m_rem > 0) begin
                m_rem--;
                m_req = (m_rem == 0);
            end else if (m_fired) begin
                if (m_db[c_LPI]) m_fired = 0;
                m_req = 1'b1;
            end else begin
                m_req = 1'b1;
                if (!m_db[c_LPI]) begin
                    m_run++;
                    // First pressed edge arms, then c_LP more edges of hold.
                    if (m_run == c_LP + 1) begin
                        m_rem = c_RP; m_req = 1'b0; m_fired = 1; m_run = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end
            for (int i = 0; i < c_N; i++) begin
                if (m_p2[i] != m_db[i]) begin
                    m_mis[i]++;
                    if (m_mis[i] == c_DB) begin
                        m_db[i] = m_p2[i]; m_mis[i] = 0;
                    end
                end else begin
                    m_mis[i] = 0;
                end
            end
            m_p2 = m_p1;
            m_p1 = {dip_raw, btn_raw};
        end
        e.bdb = m_db[c_NB-1:0]; e.ddb = m_db[c_N-1:c_NB];
        e.pulse = m_pulse; e.req = m_req;
        q.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL queue_empty at %0t: got 0 entries expected 1", $time);
        end else begin
            e = q.pop_front();
            check("button_db_n", 8'(btn_db), 8'(e.bdb));
            check("dipsw_db",    8'(dip_db), 8'(e.ddb));
            check("press_pulse", 8'(press),  8'(e.pulse));
            check("warm_req_n",  8'(req_n),  8'(e.req));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    int btn_left[c_NB];
    int dip_left[c_ND];

    initial begin
        rst_n = 1'b0; btn_raw = 2'b11; dip_raw = 4'h5; lp_en = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(20);
        // Short glitch, then a real press and release on button 1.
        btn_raw[1] = 1'b0; cyc(3); btn_raw[1] = 1'b1; cyc(10);
        btn_raw[1] = 1'b0; cyc(20); btn_raw[1] = 1'b1; cyc(20);
        // Long hold on the watched button.
        lp_en = 1'b1;
        btn_raw[0] = 1'b0; cyc(70); btn_raw[0] = 1'b1; cyc(20);
        // Disarm during the pulse, then a too-short press.
        btn_raw[0] = 1'b0; cyc(28); lp_en = 1'b0; cyc(10);
        lp_en = 1'b1; btn_raw[0] = 1'b1; cyc(15);
        btn_raw[0] = 1'b0; cyc(15); btn_raw[0] = 1'b1; cyc(15);
        // Reset mid-pulse, then mid-debounce.
        btn_raw[0] = 1'b0; cyc(29); rst_n = 1'b0; cyc(2); rst_n = 1'b1;
        cyc(10); btn_raw[0] = 1'b1; cyc(40);
        dip_raw = 4'hA; cyc(3); rst_n = 1'b0; cyc(2); rst_n = 1'b1; cyc(20);
        // Randomised traffic.
        for (int i = 0; i < c_NB; i++) btn_left[i] = 1;
        for (int i = 0; i < c_ND; i++) dip_left[i] = 1;
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < c_NB; i++) begin
                btn_left[i]--;
                if (btn_left[i] <= 0) begin
                    btn_raw[i] = ~btn_raw[i];
                    btn_left[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                                               : $urandom_range(5, 60);
                end
            end
            for (int i = 0; i < c_ND; i++) begin
                dip_left[i]--;
                if (dip_left[i] <= 0) begin
                    dip_raw[i] = ~dip_raw[i];
                    dip_left[i] = $urandom_range(1, 30);
                end
            end
            if ($urandom_range(0, 199) == 0) lp_en = ~lp_en;
            rst_n = ($urandom_range(0, 499) != 0);
            cyc(1);
        end
        rst_n = 1'b1;
        cyc(3);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
